// File: rtl/sha256_padder.sv
// SHA-256 message padder: streams message words, appends 0x80,
// zero fill and the 64-bit bit length in 512-bit blocks.
module sha256_padder (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [31:0] msg_len,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        out_last_word,
  output logic        out_last_block,
  output logic        busy,
  output logic        done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_MSG,
    S_PAD,
    S_ZERO,
    S_LEN_HI,
    S_LEN_LO
  } state_t;

  state_t      r_state;
  state_t      w_next;
  state_t      w_pad_nxt;
  logic [31:0] r_len;
  logic [29:0] r_mc;
  logic [3:0]  r_wc;
  logic [26:0] r_blk;
  logic [26:0] r_last_blk;
  logic        r_done;
  logic [30:0] w_nwords;
  logic [26:0] w_last_blk;
  logic        w_final;
  logic        w_ohs;
  logic [31:0] w_tail;

  assign w_nwords = {1'b0, r_len[31:2]}
                  + {30'd0, |r_len[1:0]};
  assign w_final  = ({1'b0, r_mc} + 31'd1) == w_nwords;
  // Index of the block holding the length field: floor((len+8)/64)
  assign w_last_blk = {1'b0, msg_len[31:6]}
                    + {26'd0, msg_len[5:0] >= 6'd56};
  assign w_ohs     = out_valid && out_ready;
  assign w_pad_nxt = (r_wc == 4'd13) ? S_LEN_HI : S_ZERO;

  always_comb begin
    w_tail = in_data;
    unique case (r_len[1:0])
      2'd1:    w_tail = {in_data[31:24], 24'h800000};
      2'd2:    w_tail = {in_data[31:16], 16'h8000};
      2'd3:    w_tail = {in_data[31:8], 8'h80};
      default: w_tail = in_data;
    endcase
  end

  always_comb begin
    w_next    = r_state;
    in_ready  = 1'b0;
    out_valid = 1'b1;
    out_data  = 32'h0;
    unique case (r_state)
      S_IDLE: begin
        out_valid = 1'b0;
        if (start)
          w_next = (msg_len == 32'd0) ? S_PAD : S_MSG;
      end
      S_MSG: begin
        in_ready  = out_ready;
        out_valid = in_valid;
        out_data  = w_final ? w_tail : in_data;
        if (w_ohs && w_final)
          w_next = (r_len[1:0] == 2'd0) ? S_PAD : w_pad_nxt;
      end
      S_PAD: begin
        out_data = 32'h8000_0000;
        if (w_ohs) w_next = w_pad_nxt;
      end
      S_ZERO: begin
        if (w_ohs && r_wc == 4'd13) w_next = S_LEN_HI;
      end
      S_LEN_HI: begin
        out_data = {29'd0, r_len[31:29]};
        if (w_ohs) w_next = S_LEN_LO;
      end
      S_LEN_LO: begin
        out_data = {r_len[28:0], 3'b000};
        if (w_ohs) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= S_IDLE;
      r_len      <= 32'd0;
      r_mc       <= 30'd0;
      r_wc       <= 4'd0;
      r_blk      <= 27'd0;
      r_last_blk <= 27'd0;
      r_done     <= 1'b0;
    end else begin
      r_state <= w_next;
      r_done  <= 1'b0;
      if (r_state == S_IDLE) begin
        if (start) begin
          r_len      <= msg_len;
          r_last_blk <= w_last_blk;
          r_mc       <= 30'd0;
          r_wc       <= 4'd0;
          r_blk      <= 27'd0;
        end
      end else if (w_ohs) begin
        r_wc <= r_wc + 4'd1;
        if (r_wc == 4'd15) r_blk <= r_blk + 27'd1;
        if (r_state == S_MSG) r_mc <= r_mc + 30'd1;
        if (r_state == S_LEN_LO) r_done <= 1'b1;
      end
    end
  end

  assign busy           = (r_state != S_IDLE);
  assign out_last_word  = busy && (r_wc == 4'd15);
  assign out_last_block = busy && (r_blk == r_last_blk);
  assign done           = r_done;

endmodule

// File: doc/sha256_padder.md
# sha256_padder

Streaming SHA-256 message padder that sits directly upstream of the SHA-256 compression core. It takes raw big-endian message words and a byte length. It emits the fully padded message as a stream of 32-bit words grouped into 512-bit (16-word) blocks, in the order the core consumes them (W[0]..W[15] per block). It appends the 0x80 marker, the zero fill and the 64-bit bit-length, inserting an extra block when needed.

## Interface
Parameters:
- none; block size 16 words and word width 32 are fixed by SHA-256.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- reset_n  in  1  reset, asynchronous, active-low.
- start  in  1  one-cycle request; sampled only in IDLE.
- msg_len  in  32  message length in bytes, latched on accepted start.
- in_valid  in  1  in_data holds a message word.
- in_ready  out  1  padder accepts in_data this cycle.
- in_data  in  32  message word; byte 0 in [31:24]; unused bytes of the final partial word are don't-care.
- out_valid  out  1  out_data holds a padded word.
- out_ready  in  1  downstream accepts out_data this cycle.
- out_data  out  32  padded word.
- out_last_word  out  1  out_data is word 15 of a block.
- out_last_block  out  1  out_data belongs to the final block.
- busy  out  1  high from accepted start until the final word handshake.
- done  out  1  one-cycle pulse in the cycle after the final word handshake.

## Operation
- States: IDLE, MSG, PAD, ZERO, LEN_HI, LEN_LO.
- On start in IDLE:
  - latch len = msg_len, N = ceil(len/4), r = len mod 4;
  - clear word counter wc (0..15), message word counter mc, and block count;
  - next state MSG, or PAD if len == 0.
- MSG:
  - pass-through; in_ready = out_ready and out_valid = in_valid.
  - Words 0..N-2 are forwarded unmodified.
  - Word N-1 with r == 0 is forwarded unmodified, then the state goes to PAD.
  - Word N-1 with r != 0:
    - keep bytes 0..r-1;
    - put 0x80 in byte r;
    - zero the remaining bytes;
    - this word counts as the pad word, and the next state is chosen by the pad rule.
- PAD: emit 0x80000000 (in_ready = 0), then apply the pad rule.
- Pad rule: let p be the block position of the pad word.
  - p <= 13: go to ZERO, emit zeros through position 13, then go to LEN_HI.
  - p >= 14: emit zeros through position 15 of this block and positions 0..13 of a new block, then go to LEN_HI.
- LEN_HI emits len[31:29] zero-extended (bits 63:32 of 8*len). LEN_LO emits {len[28:0], 3'b000}.
- After LEN_LO: IDLE, pulse done.
- Total blocks B = floor((len+8)/64)+1; total words = 16*B.
- wc increments on every output handshake and wraps from 15 to 0.
- out_last_word = (wc == 15).
- out_last_block is high for all words once the current block is known to be the last: the block containing LEN_HI/LEN_LO.
- Outside MSG, in_ready = 0.
- In non-MSG states, out_valid = 1 except in IDLE.
- start while busy is ignored.
- in_valid outside MSG is ignored.

## Timing
- Reset values:
  - state IDLE;
  - in_ready 0, out_valid 0, out_data 0;
  - out_last_word 0, out_last_block 0;
  - busy 0, done 0.
- Reset mid-operation aborts immediately; no partial block is completed, and done does not pulse.
- Latency:
  - start accepted at edge T, so the first out_valid is possible in cycle T+1.
  - MSG words have zero latency (combinational pass-through).
  - Generated words are produced at one per cycle when out_ready = 1.
- Handshake: a transfer occurs when valid && ready on a rising edge.
  - While out_valid = 1 and out_ready = 0, out_data, out_last_word and out_last_block hold stable.
- Back-to-back: start is accepted in the same cycle done is high, because the state is IDLE then.
- Minimum message duration is 16 output handshakes (len == 0).

## Test plan
- len=3, in_data 0x616263xx:
  - word 0 = 0x61626380;
  - words 1..14 = 0;
  - word 15 = 0x00000018;
  - last_word on word 15, last_block high throughout;
  - done one cycle after.
- len=0, start only, no input words:
  - word 0 = 0x80000000;
  - words 1..15 = 0;
  - in_ready never asserted.
- len=55:
  - 14 input words; word 13 byte 3 = 0x80;
  - word 14 = 0, word 15 = 0x000001B8;
  - one block.
- len=56:
  - word 14 = 0x80000000;
  - words 15..29 = 0;
  - word 30 = 0, word 31 = 0x000001C0;
  - out_last_word on words 15 and 31;
  - out_last_block only on words 16..31.
- len=64:
  - words 0..15 are message;
  - word 16 = 0x80000000;
  - word 31 = 0x00000200.
- Random out_ready/in_valid throttling at len=100: output identical to the unthrottled run, and data stable while stalled.
- Reset asserted mid-block: all outputs 0 asynchronously, no done, and a subsequent start works normally.
